uart_frame_scheduler: RTL

- Round-robin scheduler that shares one byte-wide UART transmitter between NUM_CH ring-oscillator count channels.
- On each grant it captures one channel's count and sequences the transmitter byte by byte: header, channel id, count bytes MSB first, and an optional checksum.
- It drives the transmitter's start/data inputs, uses the transmitter's busy output as the handshake, and reports frame status upstream.

---
 rtl/uart_frame_scheduler_if.sv | 27 ++
 rtl/uart_frame_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_frame_scheduler_if.sv
// Bundle between uart_frame_scheduler and its environment: the channel request
// and ack lines, the byte-wide UART transmitter handshake, and the frame status.
// The scheduler connects to the master modport. The environment (the requesting
// channels plus the UART) connects to the slave modport.
interface uart_frame_scheduler_if #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned COUNT_W = 16
);
    logic [NUM_CH-1:0]         req;
    logic [NUM_CH*COUNT_W-1:0] count_flat;
    logic [NUM_CH-1:0]         ack;
    logic                      uart_start;
    logic [7:0]                uart_data;
    logic                      uart_busy;
    logic                      frame_busy;
    logic                      frame_done;

    modport master (
        input  req, count_flat, uart_busy,
        output ack, uart_start, uart_data, frame_busy, frame_done
    );

    modport slave (
        output req, count_flat, uart_busy,
        input  ack, uart_start, uart_data, frame_busy, frame_done
    );
endinterface

// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler: a round-robin arbiter in front of one byte-wide UART
// transmitter. On each grant it captures the winning channel's count and sends
// the frame HEADER, channel id, and count bytes (MSB first).
// Define CHECKSUM_EN to append an XOR checksum byte to every frame.
module uart_frame_scheduler #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned COUNT_W = 16,
    parameter logic [7:0]  HEADER  = 8'hA5
) (
    input logic                    clk,
    input logic                    rst_n,
    uart_frame_scheduler_if.master bus
);

`ifdef CHECKSUM_EN
    localparam int unsigned CHK_BYTES = 1;
`else
    localparam int unsigned CHK_BYTES = 0;
`endif
    localparam int unsigned NB       = 2 + COUNT_W / 8 + CHK_BYTES;
    localparam logic [2:0]  IDX_LAST = 3'(NB - 1);
    localparam logic [2:0]  CH_LAST  = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {StIdle, StGrant, StLoad, StWait, StDone} state_e;

    state_e             state_q, state_d;
    logic [2:0]         rr_q, rr_d;
    logic [2:0]         idx_q, idx_d;
    logic [2:0]         id_q, id_d;
    // Count bytes are taken from the top and shifted out as the frame advances.
    logic [COUNT_W-1:0] shadow_q, shadow_d;
`ifdef CHECKSUM_EN
    logic [7:0]         chk_q, chk_d;
`endif

    logic [7:0] req_ext;
    logic [3:0] cand;
    logic       gnt_found;
    logic [2:0] gnt_idx;
    logic [7:0] cur_byte;

    assign req_ext = 8'(bus.req);

    // Round-robin search: first set request at or above rr_q, wrapping at NUM_CH.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 3'd0;
        cand      = 4'd0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = 4'(rr_q) + 4'(i);
            if (cand >= 4'(NUM_CH)) begin
                cand = cand - 4'(NUM_CH);
            end
            if (!gnt_found && req_ext[cand[2:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[2:0];
            end
        end
    end

    // Byte presented to the UART for the current frame index.
    always_comb begin
        cur_byte = shadow_q[COUNT_W-1 -: 8];
        if (idx_q == 3'd0) begin
            cur_byte = HEADER;
        end else if (idx_q == 3'd1) begin
            cur_byte = {5'b00000, id_q};
`ifdef CHECKSUM_EN
        end else if (idx_q == IDX_LAST) begin
            cur_byte = chk_q;
`endif
        end
    end

    // Frame sequencer: next state, datapath updates, and all outputs.
    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        idx_d          = idx_q;
        id_d           = id_q;
        shadow_d       = shadow_q;
`ifdef CHECKSUM_EN
        chk_d          = chk_q;
`endif
        bus.ack        = '0;
        bus.uart_start = 1'b0;
        bus.uart_data  = 8'h00;
        bus.frame_busy = 1'b0;
        bus.frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A busy UART is still finishing an earlier byte; hold off the grant.
                if (|bus.req && !bus.uart_busy) begin
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (gnt_found) begin
                    bus.frame_busy = 1'b1;
                    id_d           = gnt_idx;
                    rr_d           = (gnt_idx == CH_LAST) ? 3'd0 : gnt_idx + 3'd1;
                    idx_d          = 3'd0;
`ifdef CHECKSUM_EN
                    chk_d          = 8'h00;
`endif
                    for (int unsigned k = 0; k < NUM_CH; k++) begin
                        if (gnt_idx == 3'(k)) begin
                            shadow_d   = bus.count_flat[k*COUNT_W +: COUNT_W];
                            bus.ack[k] = 1'b1;
                        end
                    end
                    state_d = StLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            StLoad: begin
                bus.frame_busy = 1'b1;
                bus.uart_start = 1'b1;
                bus.uart_data  = cur_byte;
                // Busy seen high means the UART has taken this byte.
                if (bus.uart_busy) begin
`ifdef CHECKSUM_EN
                    chk_d = chk_q ^ cur_byte;
`endif
                    state_d = StWait;
                end
            end
            StWait: begin
                bus.frame_busy = 1'b1;
                bus.uart_data  = cur_byte;
                if (!bus.uart_busy) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = StDone;
                    end else begin
                        if (idx_q >= 3'd2) begin
                            shadow_d = shadow_q << 8;
                        end
                        idx_d   = idx_q + 3'd1;
                        state_d = StLoad;
                    end
                end
            end
            StDone: begin
                bus.frame_done = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rr_q     <= 3'd0;
            idx_q    <= 3'd0;
            id_q     <= 3'd0;
            shadow_q <= '0;
`ifdef CHECKSUM_EN
            chk_q    <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            idx_q    <= idx_d;
            id_q     <= id_d;
            shadow_q <= shadow_d;
`ifdef CHECKSUM_EN
            chk_q    <= chk_d;
`endif
        end
    end

endmodule
